hazard_fwd_ctrl: RTL and testbench

Sequencing controller for the two EX-stage 3:1 operand-forwarding muxes in the 5-stage pipelined RV32I core.
- Keeps shadow copies of destination/control info for the EX, MEM and WB stages.
- Drives the mux select codes.
- Detects load-use hazards and generates the IF/ID stall and EX bubble.
- Handles branch-taken flushes.
- Sits beside the datapath; the decoder and the EX branch unit feed it.

---
 rtl/hazard_fwd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Purpose: tracks EX/MEM/WB destinations and drives the EX forwarding selects, load-use stall and branch flush.
// Latency: selects, stall and flush are combinational; shadow state advances on each unfrozen clk edge.
// Backpressure: ext_stall freezes all tracking and masks stall/flush; HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ext_stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    // Shadow copies of the instruction in each downstream stage
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
    logic              ex_rw_q,  ex_rw_d;
    logic              ex_mr_q,  ex_mr_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_rw_q, mem_rw_d;
    logic [REG_AW-1:0] wb_rd_q,  wb_rd_d;
    logic              wb_rw_q,  wb_rw_d;

    logic load_use;
    logic active;
    logic stall_now;
    logic flush_now;

    // Forward selects: the youngest producer (MEM) wins over WB; x0 never forwards
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (mem_rw_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
            fwd_a_sel = 2'b10;
        end else if (wb_rw_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
            fwd_a_sel = 2'b01;
        end
        if (mem_rw_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
            fwd_b_sel = 2'b10;
        end else if (wb_rw_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
            fwd_b_sel = 2'b01;
        end
    end

    // Hazard detection: a taken branch discards the dependent anyway, so it masks load-use;
    // a frozen pipeline or reset masks both
    always_comb begin
        load_use   = ex_mr_q && (ex_rd_q != '0) && ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
        active     = rst_n && !ext_stall;
        flush_now  = active && ex_branch_taken;
        stall_now  = active && load_use && !ex_branch_taken;
        stall_pc   = stall_now;
        stall_ifid = stall_now;
        flush_ifid = flush_now;
        flush_idex = flush_now || stall_now;
    end

    // Next shadow state: shift one stage per unfrozen cycle, inserting a bubble into EX on flush/stall
    always_comb begin
        ex_rs1_d = ex_rs1_q;
        ex_rs2_d = ex_rs2_q;
        ex_rd_d  = ex_rd_q;
        ex_rw_d  = ex_rw_q;
        ex_mr_d  = ex_mr_q;
        mem_rd_d = mem_rd_q;
        mem_rw_d = mem_rw_q;
        wb_rd_d  = wb_rd_q;
        wb_rw_d  = wb_rw_q;
        if (!ext_stall) begin
            wb_rd_d  = mem_rd_q;
            wb_rw_d  = mem_rw_q;
            mem_rd_d = ex_rd_q;
            mem_rw_d = ex_rw_q;
            if (flush_idex) begin
                ex_rs1_d = '0;
                ex_rs2_d = '0;
                ex_rd_d  = '0;
                ex_rw_d  = 1'b0;
                ex_mr_d  = 1'b0;
            end else begin
                ex_rs1_d = id_rs1;
                ex_rs2_d = id_rs2;
                ex_rd_d  = id_rd;
                ex_rw_d  = id_reg_write;
                ex_mr_d  = id_mem_read;
            end
        end
    end

    // Shadow state registers; reset drops every in-flight entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else begin
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            ex_rd_q  <= ex_rd_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            mem_rd_q <= mem_rd_d;
            mem_rw_q <= mem_rw_d;
            wb_rd_q  <= wb_rd_d;
            wb_rw_q  <= wb_rw_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; stall_now/flush_now are already zero while frozen
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_now && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_now && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Purpose: directed pipeline sequences for hazard_fwd_ctrl with a queued expectation scoreboard.
// Latency: each vector is driven just after a rising edge and checked on the following falling edge.
// Backpressure: ext_stall windows are part of the stimulus; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_fwd_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_read;
    logic        ex_branch_taken, ext_stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall_pc, stall_ifid, flush_ifid, flush_idex;
    logic [31:0] stall_cycles, flush_events;

    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ext_stall       (ext_stall),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       spc;
        logic       fif;
        logic       fex;
        int         sc;
        int         fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input longint act, input longint req);
        if (act != req) begin
            $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, req);
            n_miss++;
        end
    endtask

    // Monitor: every falling edge with a pending expectation is one observed output vector
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            chk(e.name, "fwd_a_sel",    fwd_a_sel,    e.fa);
            chk(e.name, "fwd_b_sel",    fwd_b_sel,    e.fb);
            chk(e.name, "stall_pc",     stall_pc,     e.spc);
            chk(e.name, "stall_ifid",   stall_ifid,   e.spc);
            chk(e.name, "flush_ifid",   flush_ifid,   e.fif);
            chk(e.name, "flush_idex",   flush_idex,   e.fex);
            chk(e.name, "stall_cycles", stall_cycles, PERF ? e.sc : 0);
            chk(e.name, "flush_events", flush_events, PERF ? e.fe : 0);
        end
    end

    // Drive one cycle of ID/control inputs and queue the hand-computed response
    task automatic step(input string nm, input logic rstv,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic br, input logic xs,
                        input logic [1:0] efa, input logic [1:0] efb,
                        input logic espc, input logic efif, input logic efex,
                        input int esc, input int efe);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rstv;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rd           = rd;
        id_reg_write    = rw;
        id_mem_read     = mr;
        ex_branch_taken = br;
        ext_stall       = xs;
        e.name = nm; e.fa = efa; e.fb = efb; e.spc = espc; e.fif = efif; e.fex = efex;
        e.sc = esc; e.fe = efe;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ext_stall = 1'b0;

        //    name        rst rs1 rs2 rd rw mr br xs  fa     fb    spc fif fex sc fe
        step("reset",     0,  8,  8,  9, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        // add x5,x1,x2 ; sub x6,x5,x3 ; then frozen for three cycles
        step("c1_add",    1,  1,  2,  5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("c1_sub",    1,  5,  3,  6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("frz1",      1,  0,  0,  0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        step("frz2_br",   1,  0,  0,  0, 0, 0, 1, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        step("frz3",      1,  0,  0,  0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        step("c1_ex",     1,  0,  0,  0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        // add x5 ; nop ; or x7,x4,x5
        step("c2_add",    1,  1,  2,  5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("c2_nop",    1,  0,  0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("c2_or",     1,  4,  5,  7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("c2_ex",     1,  0,  0,  0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        // lw x8,0(x2) ; add x9,x8,x8 (held one cycle in ID)
        step("c3_lw",     1,  2,  0,  8, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("c3_lu",     1,  8,  8,  9, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);
        step("c3_held",   1,  8,  8,  9, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        step("c3_ex",     1,  0,  0,  0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 1, 0);
        // add x5 ; add x5 ; sub x6,x5,x5 ; add x0 ; add x3,x0,x0
        step("c4_add_a",  1,  1,  2,  5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        step("c4_add_b",  1,  1,  2,  5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        step("c4_sub",    1,  5,  5,  6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        step("c4_prio",   1,  1,  2,  0, 1, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 1, 0);
        step("c4_rdx0",   1,  0,  0,  3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        step("c4_memx0",  1,  0,  0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        // lw x8 then dependent with a taken branch in the same cycle
        step("c5_lw_wbx0",1,  2,  0,  8, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        step("c5_flush",  1,  8,  8,  9, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0);
        step("c5_after",  1,  0,  0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1);
        // rebuild a MEM forward, then assert reset while it is live
        step("c6_add",    1,  1,  2,  5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1);
        step("c6_sub",    1,  5,  3,  6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1);
        step("c6_fwd",    1,  0,  0,  0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 1, 1);
        step("c6_arst",   0,  8,  8,  9, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("c6_rel",    1,  0,  0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
